// File: rtl/qint_vector_pkg.sv
// Shared definitions for the QBUS interrupt-vector responder:
// state encoding, default timing constants and the DAL word builder.
package qint_vector_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        REPLY,
        HOLD,
        WAIT_REL
    } state_e;

    localparam int unsigned CNT_W            = 16;
    localparam int unsigned DEF_SETUP_CYCLES = 3;
    localparam int unsigned DEF_DIN_TIMEOUT  = 200;

    // The configured bits sit at [8:2]; the vector is always longword aligned.
    function automatic logic [15:0] vector_word(input logic [8:2] vec);
        return {7'b0, vec, 2'b00};
    endfunction

endpackage

// File: rtl/qint_vector_if.sv
// QBUS-side signals of the vector responder: init/DIN in, DAL data and RPLY out.
interface qint_vector_if;
    logic        RINIT;
    logic        RDIN;
    logic [15:0] TDAL;
    logic        TDAL_en;
    logic        TRPLY;

    modport master (output RINIT, RDIN, input TDAL, TDAL_en, TRPLY);
    modport slave  (input RINIT, RDIN, output TDAL, TDAL_en, TRPLY);
endinterface

// File: rtl/qint_vector_qsync.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module qsync (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic meta_q;
    logic sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/qint_vector.sv
// QBUS interrupt-acknowledge responder: drives the vector on DAL, answers DIN
// with RPLY, and reports service (vector_taken) or a stuck DIN (din_timeout).
module qint_vector
    import qint_vector_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES = DEF_SETUP_CYCLES,
    parameter int unsigned DIN_TIMEOUT  = DEF_DIN_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset_n,
    qint_vector_if.slave       bus,
    input  logic               assert_vector,
    input  logic [8:2]         vector,
    output logic               vector_taken,
    output logic               din_timeout
);
    logic rinit_s, rdin_s, av_s;

    qsync u_sync_rinit (.clk(clk), .reset_n(reset_n), .d(bus.RINIT),    .q(rinit_s));
    qsync u_sync_rdin  (.clk(clk), .reset_n(reset_n), .d(bus.RDIN),     .q(rdin_s));
    qsync u_sync_av    (.clk(clk), .reset_n(reset_n), .d(assert_vector), .q(av_s));

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        tdal_q, tdal_d;
    logic               tdal_en_q, tdal_en_d;
    logic               trply_q, trply_d;
    logic               taken_q, taken_d;
    logic               dto_q, dto_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dto_d   = dto_q;

        if (rinit_s) begin
            state_d = IDLE;
            cnt_d   = '0;
            dto_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (av_s && rdin_s) begin
                        state_d = SETUP;
                        cnt_d   = CNT_W'(SETUP_CYCLES - 1);
                    end
                end
                SETUP: begin
                    // A withdrawn request abandons the cycle before RPLY is ever driven.
                    if (!av_s) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == '0) begin
                        state_d = REPLY;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                REPLY: begin
                    if (!rdin_s) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(DIN_TIMEOUT - 1)) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                        dto_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                HOLD:     state_d = WAIT_REL;
                WAIT_REL: if (!av_s && !rdin_s) state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    // Outputs decode the next state so they are registered and line up with it.
    always_comb begin
        tdal_en_d = (state_d == SETUP) || (state_d == REPLY) || (state_d == HOLD);
        trply_d   = (state_d == REPLY);
        taken_d   = (state_q == HOLD) && (state_d == WAIT_REL);
        if (state_d == IDLE)       tdal_d = '0;
        else if (state_q == IDLE)  tdal_d = vector_word(vector);
        else                       tdal_d = tdal_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tdal_q    <= '0;
            tdal_en_q <= 1'b0;
            trply_q   <= 1'b0;
            taken_q   <= 1'b0;
            dto_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tdal_q    <= tdal_d;
            tdal_en_q <= tdal_en_d;
            trply_q   <= trply_d;
            taken_q   <= taken_d;
            dto_q     <= dto_d;
        end
    end

    assign bus.TDAL    = tdal_q;
    assign bus.TDAL_en = tdal_en_q;
    assign bus.TRPLY   = trply_q;
    assign vector_taken = taken_q;
    assign din_timeout  = dto_q;
endmodule

// File: tb/tb_qint_vector.sv
// Directed bench for qint_vector: table of full acknowledge cycles plus
// hand-written sequences for timeout, abort, RINIT, vector change and reset.
module tb_qint_vector;
    logic       clk;
    logic       reset_n;
    logic       assert_vector;
    logic [8:2] vector;
    logic       vector_taken;
    logic       din_timeout;

    qint_vector_if bus ();

    qint_vector #(.SETUP_CYCLES(3), .DIN_TIMEOUT(200)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus           (bus.slave),
        .assert_vector (assert_vector),
        .vector        (vector),
        .vector_taken  (vector_taken),
        .din_timeout   (din_timeout)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int taken_cnt = 0;
    int trply_cnt = 0;

    always @(negedge clk) begin
        if (vector_taken) taken_cnt++;
        if (bus.TRPLY)    trply_cnt++;
    end

    typedef struct {
        logic [8:2]  vec;
        logic [15:0] exp_tdal;
    } vec_rec_t;

    vec_rec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // One complete acknowledge: request, DIN, RPLY, DIN release, HOLD, taken pulse.
    task automatic run_cycle(input logic [8:2] vec, input logic [15:0] exp_tdal);
        int t0;
        t0 = taken_cnt;
        vector = vec;
        bus.RDIN = 1'b1;
        assert_vector = 1'b1;
        tick(3);
        check("setup_en", bus.TDAL_en, 1);
        check("setup_tdal", bus.TDAL, exp_tdal);
        check("setup_trply", bus.TRPLY, 0);
        tick(2);
        check("trply_not_early", bus.TRPLY, 0);
        tick(1);
        check("trply_rise", bus.TRPLY, 1);
        check("reply_tdal", bus.TDAL, exp_tdal);
        bus.RDIN = 1'b0;
        tick(2);
        check("trply_until_sync", bus.TRPLY, 1);
        tick(1);
        check("hold_trply", bus.TRPLY, 0);
        check("hold_en", bus.TDAL_en, 1);
        check("hold_no_taken", vector_taken, 0);
        tick(1);
        check("taken_pulse", vector_taken, 1);
        check("wait_en", bus.TDAL_en, 0);
        tick(1);
        check("taken_end", vector_taken, 0);
        assert_vector = 1'b0;
        tick(3);
        check("idle_tdal", bus.TDAL, 0);
        check("one_taken", taken_cnt - t0, 1);
    endtask

    initial begin
        int hi_cnt;
        int t0;
        int r0;

        tbl[0] = '{7'o15,  16'o000064};
        tbl[1] = '{7'o0,   16'o000000};
        tbl[2] = '{7'o177, 16'o000774};
        tbl[3] = '{7'o100, 16'o000400};
        tbl[4] = '{7'o52,  16'o000250};

        reset_n = 1'b0;
        assert_vector = 1'b0;
        vector = 7'o15;
        bus.RINIT = 1'b0;
        bus.RDIN = 1'b0;
        tick(2);
        check("rst_tdal", bus.TDAL, 0);
        check("rst_en", bus.TDAL_en, 0);
        check("rst_trply", bus.TRPLY, 0);
        check("rst_taken", vector_taken, 0);
        check("rst_dto", din_timeout, 0);
        reset_n = 1'b1;
        tick(2);

        for (int i = 0; i < 5; i++) run_cycle(tbl[i].vec, tbl[i].exp_tdal);

        // Stuck DIN: RPLY forced off after exactly 200 clocks.
        vector = 7'o15;
        bus.RDIN = 1'b1;
        assert_vector = 1'b1;
        tick(6);
        check("to_trply_rise", bus.TRPLY, 1);
        hi_cnt = 1;
        for (int k = 0; k < 300; k++) begin
            tick(1);
            if (!bus.TRPLY) break;
            hi_cnt++;
        end
        check("to_high_clks", hi_cnt, 200);
        check("to_flag", din_timeout, 1);
        r0 = trply_cnt;
        tick(50);
        check("to_no_retrigger", trply_cnt - r0, 0);
        bus.RDIN = 1'b0;
        assert_vector = 1'b0;
        tick(4);
        check("to_sticky", din_timeout, 1);
        bus.RINIT = 1'b1;
        tick(1);
        bus.RINIT = 1'b0;
        tick(3);
        check("to_cleared", din_timeout, 0);

        // Request withdrawn during the second SETUP clock.
        t0 = taken_cnt;
        r0 = trply_cnt;
        bus.RDIN = 1'b1;
        assert_vector = 1'b1;
        tick(2);
        assert_vector = 1'b0;
        tick(1);
        check("abort_setup_en", bus.TDAL_en, 1);
        tick(2);
        check("abort_idle_en", bus.TDAL_en, 0);
        check("abort_idle_tdal", bus.TDAL, 0);
        tick(6);
        check("abort_no_trply", trply_cnt - r0, 0);
        check("abort_no_taken", taken_cnt - t0, 0);
        bus.RDIN = 1'b0;
        tick(3);

        // RINIT during REPLY.
        t0 = taken_cnt;
        bus.RDIN = 1'b1;
        assert_vector = 1'b1;
        tick(6);
        check("rinit_in_reply", bus.TRPLY, 1);
        bus.RINIT = 1'b1;
        tick(2);
        check("rinit_sync_delay", bus.TRPLY, 1);
        tick(1);
        check("rinit_trply", bus.TRPLY, 0);
        check("rinit_en", bus.TDAL_en, 0);
        bus.RDIN = 1'b0;
        assert_vector = 1'b0;
        tick(3);
        bus.RINIT = 1'b0;
        tick(4);
        check("rinit_no_taken", taken_cnt - t0, 0);
        check("rinit_idle_en", bus.TDAL_en, 0);

        // Vector changed mid-REPLY must not disturb the cycle in progress.
        vector = 7'o15;
        bus.RDIN = 1'b1;
        assert_vector = 1'b1;
        tick(6);
        vector = 7'o100;
        tick(5);
        check("vchg_reply_tdal", bus.TDAL, 16'o000064);
        check("vchg_trply", bus.TRPLY, 1);
        bus.RDIN = 1'b0;
        tick(3);
        check("vchg_hold_tdal", bus.TDAL, 16'o000064);
        assert_vector = 1'b0;
        tick(4);
        check("vchg_idle_tdal", bus.TDAL, 0);

        // Asynchronous reset in the middle of SETUP.
        bus.RDIN = 1'b1;
        assert_vector = 1'b1;
        tick(3);
        check("ares_setup_en", bus.TDAL_en, 1);
        #5;
        reset_n = 1'b0;
        #1;
        check("ares_en", bus.TDAL_en, 0);
        check("ares_tdal", bus.TDAL, 0);
        check("ares_trply", bus.TRPLY, 0);
        check("ares_taken", vector_taken, 0);
        bus.RDIN = 1'b0;
        assert_vector = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(5);
        check("ares_idle_en", bus.TDAL_en, 0);
        check("ares_idle_trply", bus.TRPLY, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/qint_vector.md
QINT_VECTOR -- requirements
Module: qint_vector

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 3, the clk cycles the vector is driven on DAL before TRPLY asserts (150 ns at 20 MHz).
REQ-002 SHALL have parameter DIN_TIMEOUT, default 200, the clk cycles TRPLY waits for RDIN negation before a forced release (10 us).
REQ-003 SHALL have port clk  input  1  20 MHz system clock.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port RINIT  input  1  QBUS init, asynchronous to clk, synchronized internally.
REQ-006 SHALL have port RDIN  input  1  QBUS DIN, asynchronous, synchronized internally.
REQ-007 SHALL have port assert_vector  input  1  from qint, asynchronous level, synchronized internally.
REQ-008 SHALL have port vector  input  [8:2]  configured interrupt vector bits (vector = {vector,2'b00}).
REQ-009 SHALL have port TDAL  output  [15:0]  vector data for the DAL drivers.
REQ-010 SHALL have port TDAL_en  output  1  enables the DAL drivers.
REQ-011 SHALL have port TRPLY  output  1  QBUS RPLY.
REQ-012 SHALL have port vector_taken  output  1  one-clk pulse telling the device its interrupt was serviced.
REQ-013 SHALL have port din_timeout  output  1  sticky flag set by a forced release, cleared by reset or RINIT.

Function
REQ-014 SHALL synchronize RINIT, RDIN, and assert_vector through two flops each; all state decisions SHALL use synchronized values only.
REQ-015 SHALL implement states IDLE, SETUP, REPLY, HOLD, and WAIT_REL.
REQ-016 In IDLE, TDAL_en=0, TRPLY=0, and TDAL=0; on sync assert_vector=1 with sync RDIN=1, SHALL go to SETUP and load the setup counter with SETUP_CYCLES-1.
REQ-017 In SETUP, SHALL drive TDAL={7'b0,vector,2'b00} with TDAL_en=1 and decrement the counter; at 0, SHALL go to REPLY.
REQ-018 TDAL SHALL latch vector on entry to SETUP and hold it until return to IDLE; later vector changes SHALL NOT affect the cycle in progress.
REQ-019 In REPLY, SHALL assert TRPLY=1 and keep TDAL_en=1; on sync RDIN=0, SHALL go to HOLD.
REQ-020 In REPLY, SHALL count cycles; on reaching DIN_TIMEOUT, SHALL set din_timeout and go to HOLD.
REQ-021 In HOLD (exactly one clk), SHALL hold TRPLY=0 and TDAL_en=1, then go to WAIT_REL and pulse vector_taken for one clk.
REQ-022 In WAIT_REL, TDAL_en=0 and TRPLY=0; SHALL go to IDLE only when sync assert_vector=0 and sync RDIN=0, so each acknowledge yields exactly one vector cycle.
REQ-023 If assert_vector drops in SETUP (RDIN or IAKI withdrawn), SHALL abort to IDLE without asserting TRPLY or pulsing vector_taken.
REQ-024 Sync RINIT=1 in any state SHALL force IDLE, clear din_timeout, and deassert all outputs on the next clk.
REQ-025 TRPLY and TDAL_en SHALL be registered outputs, glitch-free.
REQ-026 Latency from sync assert_vector to TRPLY SHALL be SETUP_CYCLES+1 clks.

Reset
REQ-027 reset_n=0 SHALL asynchronously force: state IDLE, counters 0, synchronizers 0, TDAL=0, TDAL_en=0, TRPLY=0, vector_taken=0, din_timeout=0.

Structure
REQ-028 State encodings and default timing constants SHALL live in the shared qsic.vh header alongside the INTP_* codes.
REQ-029 The two-flop synchronizer SHALL be a reusable sub-module named qsync, instantiated three times.
REQ-030 qint_vector SHALL sit downstream of qint, consuming its assert_vector; vector_taken SHALL feed the device's request-clear logic.

Verification
REQ-031 vector=7'o15 (vector 064), RDIN=1, assert_vector rises -> TDAL=16'o000064 with TDAL_en=1, and TRPLY rises 4 clks after sync; RDIN drops -> TRPLY=0, one HOLD clk, then a single vector_taken pulse.
REQ-032 RDIN held high 250 clks after TRPLY -> forced release at 200 clks, din_timeout=1; RINIT pulse -> din_timeout=0.
REQ-033 assert_vector drops during SETUP cycle 2 -> IDLE, TRPLY never asserted, no vector_taken.
REQ-034 RINIT asserted during REPLY -> TRPLY=0 and TDAL_en=0 within 3 clks; no vector_taken.
REQ-035 Change vector to 7'o100 mid-REPLY -> TDAL stays 16'o000064 until the cycle ends.
REQ-036 reset_n pulsed low asynchronously mid-SETUP -> all outputs 0 immediately, then IDLE.
